pingpong_read_scheduler: RTL

- Read-side controller for the ping-pong frame buffer (`ram_logic`).
- Waits for the buffer's frame-ready pulse, then grants the whole DEPTH-word frame to one of two consumers (e.g. processing core and debug/UART dump) using round-robin arbitration.
- While a frame streams, it passes the buffer's valid/ready read handshake through to the granted consumer, counts words, and flags frame completion and frame drops.
- Sits directly between `ram_logic` read port and the consumers.

---
 rtl/fpga_template_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 39 +++
 rtl/pingpong_read_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fpga_template_pkg.sv
// fpga_template_pkg
//   Shared types and constants for the frame-buffer read path.
//   - sched_state_t : read scheduler FSM states
//   - NUM_SCHED_REQ : number of consumers the read scheduler arbitrates between
package fpga_template_pkg;

  localparam int NUM_SCHED_REQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin arbiter with an internal priority pointer.
//   Ports:
//     clk_i, rst_ni : clock, asynchronous active-low reset
//     req_i         : request vector (level)
//     advance_i     : pulse, move priority past owner_i
//     owner_i       : one-hot requester whose service just completed
//     grant_o       : combinational one-hot grant, 00 when no request
module rr_arbiter2
  import fpga_template_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_SCHED_REQ-1:0] req_i,
  input  logic                     advance_i,
  input  logic [NUM_SCHED_REQ-1:0] owner_i,
  output logic [NUM_SCHED_REQ-1:0] grant_o
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic prio_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else if (advance_i) begin
      // Favour whichever requester was not just served
      prio_q <= (owner_i == 2'b01);
    end
  end

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = prio_q ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/pingpong_read_scheduler.sv
// pingpong_read_scheduler
//   Read-side controller for the ping-pong frame buffer. On each frame-ready
//   pulse it grants the whole DEPTH-word frame to one of two consumers
//   (round-robin), passes the buffer valid/ready handshake through to the
//   granted consumer, counts words and flags frame completion / drops.
//   Ports:
//     clk_i, rst_ni          : clock, asynchronous active-low reset
//     buf_frame_ready_i      : 1-cycle pulse, new frame available in buffer
//     buf_data_i/valid_i     : buffer read data / read_valid
//     buf_ready_o            : buffer read_ready
//     req_i, ready_i         : per-consumer frame request / ready
//     grant_o, valid_o       : one-hot grant / per-consumer valid
//     data_o, last_o         : shared data, last-word marker
//     frame_done_o/drop_o    : completion / overwrite pulses
//     frame_count_o          : completed frames (wraps)
//     word_count_o           : words accepted in current frame
module pingpong_read_scheduler
  import fpga_template_pkg::*;
#(
  parameter int WIDTH       = 36,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int FRAME_CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     buf_frame_ready_i,
  input  logic signed [WIDTH-1:0]  buf_data_i,
  input  logic                     buf_valid_i,
  output logic                     buf_ready_o,
  input  logic [NUM_SCHED_REQ-1:0] req_i,
  output logic [NUM_SCHED_REQ-1:0] grant_o,
  output logic signed [WIDTH-1:0]  data_o,
  output logic [NUM_SCHED_REQ-1:0] valid_o,
  input  logic [NUM_SCHED_REQ-1:0] ready_i,
  output logic                     last_o,
  output logic                     frame_done_o,
  output logic                     frame_drop_o,
  output logic [FRAME_CNT_W-1:0]   frame_count_o,
  output logic [ADDR_WIDTH:0]      word_count_o
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  // Word counting relies on DEPTH filling the address space exactly
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pingpong_read_scheduler: DEPTH must be a power of two >= 2");
    end
  endgenerate

  sched_state_t             state_q;
  logic [NUM_SCHED_REQ-1:0] grant_q;
  logic [CNT_W-1:0]         word_cnt_q;
  logic [FRAME_CNT_W-1:0]   frame_cnt_q;
  logic                     done_q;
  logic                     drop_q;

  logic [NUM_SCHED_REQ-1:0] arb_grant;
  logic                     streaming;
  logic                     ready_sel;
  logic                     accept;
  logic                     rr_advance;

  assign streaming = (state_q == STREAM);
  assign ready_sel = |(grant_q & ready_i);
  assign accept    = streaming && buf_valid_i && ready_sel;
  // A frame-ready pulse aborts the frame even if the final word is accepted
  // in the same cycle, so the pointer only moves on a clean completion.
  assign rr_advance = accept && !buf_frame_ready_i && (word_cnt_q == LAST_WORD);

  rr_arbiter2 u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .advance_i(rr_advance),
    .owner_i  (grant_q),
    .grant_o  (arb_grant)
  );

  // Zero-latency pass-through to the granted consumer only
  generate
    for (genvar gi = 0; gi < NUM_SCHED_REQ; gi++) begin : g_valid
      assign valid_o[gi] = streaming && grant_q[gi] && buf_valid_i;
    end
  endgenerate

  assign buf_ready_o   = streaming && ready_sel;
  assign data_o        = buf_data_i;
  assign last_o        = (|valid_o) && (word_cnt_q == LAST_WORD);
  assign grant_o       = grant_q;
  assign frame_done_o  = done_q;
  assign frame_drop_o  = drop_q;
  assign frame_count_o = frame_cnt_q;
  assign word_count_o  = word_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (buf_frame_ready_i) state_q <= ARB;
        end
        ARB: begin
          if (buf_frame_ready_i) begin
            // Pending frame overwritten; arbitrate again for the new one
            drop_q <= 1'b1;
          end else if (|req_i) begin
            grant_q <= arb_grant;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (buf_frame_ready_i) begin
            drop_q     <= 1'b1;
            grant_q    <= '0;
            word_cnt_q <= '0;
            state_q    <= ARB;
          end else if (accept) begin
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_q  <= FULL_CNT;
              grant_q     <= '0;
              done_q      <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 1'b1;
              state_q     <= DONE;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          word_cnt_q <= '0;
          state_q    <= buf_frame_ready_i ? ARB : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
